// File: rtl/imem_fetch_sched.sv
// imem_fetch_sched: shares one sync-read imem between fetch and loader.
// Ports: loader ld_*, fetch ctl stall/branch/npc, decode instr/pc/pc4, mem_*.
module imem_fetch_sched #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ack,
  input  logic              ld_done,
  input  logic              stall,
  input  logic              branch,
  input  logic [31:0]       npc,
  output logic [31:0]       instr,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic              instr_valid,
  output logic              fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [32:0] SPAN = 33'd4 << ADDR_W;

  logic [1:0]  state;
  logic [31:0] fpc;
  logic [31:0] off;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] hold_q;
  logic        rd_q;
  logic        vld_q;
  logic        fault_q;
  logic        ack_q;
  logic        in_rng;
  logic        issue;

  assign off    = fpc - RESET_PC;
  assign in_rng = (fpc[1:0] == 2'b00) &&
                  ({1'b0, off} < SPAN);
  assign issue  = (state == S_FETCH) && !ld_req &&
                  !stall && in_rng;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ld_addr;
    mem_wdata = ld_data;
    unique case (1'b1)
      ld_req: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      issue: begin
        mem_en   = 1'b1;
        mem_addr = off[ADDR_W+1:2];
      end
      default: ;
    endcase
  end

  // Fresh read data right after an issue, held copy during stalls.
  assign instr       = rd_q ? mem_rdata : hold_q;
  assign pc          = pc_q;
  assign pc4         = pc4_q;
  assign instr_valid = vld_q;
  assign fault       = fault_q;
  assign ld_ack      = ack_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= S_LOAD;
      fpc     <= RESET_PC;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      hold_q  <= '0;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= ld_req;
      rd_q  <= issue;
      if (rd_q) hold_q <= mem_rdata;
      unique case (state)
        S_LOAD, S_FAULT: begin
          if (ld_done) begin
            state   <= S_FETCH;
            fpc     <= RESET_PC;
            fault_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (ld_req) begin
            state <= S_LOAD;
            vld_q <= 1'b0;
          end else if (stall) begin
            state <= S_FETCH;
          end else if (in_rng) begin
            pc_q  <= fpc;
            pc4_q <= fpc + 32'd4;
            vld_q <= 1'b1;
            fpc   <= branch ? npc : fpc + 32'd4;
          end else begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
            vld_q   <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_sched.sv
// tb_imem_fetch_sched: directed bench with a transaction-level model.
// Ports: drives loader/fetch inputs, models the sync-read memory.
module tb_imem_fetch_sched;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ack;
  logic          ld_done;
  logic          stall;
  logic          branch;
  logic [31:0]   npc;
  logic [31:0]   instr;
  logic [31:0]   pc;
  logic [31:0]   pc4;
  logic          instr_valid;
  logic          fault;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  imem_fetch_sched #(.RESET_PC(RPC), .ADDR_W(AW)) dut (
    .clk(clk), .clr_n(clr_n),
    .ld_req(ld_req), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_ack(ld_ack),
    .ld_done(ld_done), .stall(stall),
    .branch(branch), .npc(npc),
    .instr(instr), .pc(pc), .pc4(pc4),
    .instr_valid(instr_valid), .fault(fault),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] bmem [1024] = '{default: '0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else mem_rdata <= bmem[mem_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: instruction-level view of the scheduler.
  typedef enum {M_LOAD, M_FETCH, M_FAULT} mode_t;
  mode_t       m_mode;
  logic [31:0] mmem [1024] = '{default: '0};
  logic [31:0] m_fpc;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_fault;
  logic        m_ack;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_mode  = M_LOAD;
      m_fpc   = RPC;
      m_pc    = RPC;
      m_instr = '0;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_ack   = 1'b0;
    end else begin
      mode_t was;
      logic [31:0] d;
      was   = m_mode;
      m_ack = ld_req;
      d     = m_fpc - RPC;
      if (ld_req) mmem[ld_addr] = ld_data;
      if (was != M_FETCH) begin
        if (ld_done) begin
          m_mode  = M_FETCH;
          m_fpc   = RPC;
          m_fault = 1'b0;
        end
      end else if (ld_req) begin
        m_mode  = M_LOAD;
        m_valid = 1'b0;
      end else if (!stall) begin
        if (m_fpc % 4 == 0 && d < 4 * 1024) begin
          m_pc    = m_fpc;
          m_instr = mmem[d / 4];
          m_valid = 1'b1;
          m_fpc   = branch ? npc : m_fpc + 4;
        end else begin
          m_mode  = M_FAULT;
          m_fault = 1'b1;
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (clr_n) begin
      chk("m_ack", ld_ack, m_ack);
      chk("m_fault", fault, m_fault);
      chk("m_valid", instr_valid, m_valid);
      chk("m_pc", pc, m_pc);
      if (m_valid) begin
        chk("m_instr", instr, m_instr);
        chk("m_pc4", pc4, m_pc + 4);
      end
    end
  end

  task automatic rst_vals(input string nm);
    chk({nm, "_instr"}, instr, 32'h0);
    chk({nm, "_pc"}, pc, 32'h3000);
    chk({nm, "_pc4"}, pc4, 32'h3004);
    chk({nm, "_valid"}, instr_valid, 1'b0);
    chk({nm, "_fault"}, fault, 1'b0);
    chk({nm, "_ack"}, ld_ack, 1'b0);
    chk({nm, "_en"}, mem_en, 1'b0);
  endtask

  logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};

  initial begin
    clr_n = 1'b1; ld_req = 1'b0; ld_addr = '0;
    ld_data = '0; ld_done = 1'b0; stall = 1'b0;
    branch = 1'b0; npc = '0;
    #2 clr_n = 1'b0;
    #1 rst_vals("reset");
    #9 clr_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld_req = 1'b1;
      ld_addr = AW'(i);
      ld_data = vals[i];
      #1;
      chk("ld_en", mem_en, 1'b1);
      chk("ld_we", mem_we, 1'b1);
      chk("ld_addr", 32'(mem_addr), i);
    end
    @(negedge clk);
    chk("ack3", ld_ack, 1'b1);
    ld_req = 1'b0; ld_done = 1'b1;
    @(negedge clk);
    chk("ack_off", ld_ack, 1'b0);
    chk("valid_lat", instr_valid, 1'b0);
    ld_done = 1'b0;
    @(negedge clk);
    chk("w0", instr, 32'h11);
    chk("p0", pc, 32'h3000);
    @(negedge clk);
    chk("w1", instr, 32'h22);
    chk("p1", pc, 32'h3004);
    stall = 1'b1;
    #1 chk("stall_en", mem_en, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st_instr", instr, 32'h22);
      chk("st_pc", pc, 32'h3004);
      chk("st_pc4", pc4, 32'h3008);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("w2", instr, 32'h33);
    branch = 1'b1; npc = 32'h3004;
    @(negedge clk);
    chk("p3", pc, 32'h300c);
    npc = 32'h3000;
    @(negedge clk);
    chk("slot", instr, 32'h22);
    chk("slot_pc", pc, 32'h3004);
    branch = 1'b0;
    @(negedge clk);
    chk("tgt", instr, 32'h11);
    chk("tgt_pc", pc, 32'h3000);
    stall = 1'b1; branch = 1'b1; npc = 32'h3100;
    @(negedge clk);
    stall = 1'b0; branch = 1'b0;
    @(negedge clk);
    chk("br_ign", pc, 32'h3004);
    branch = 1'b1; npc = 32'h3002;
    @(negedge clk);
    chk("mis_pc", pc, 32'h3008);
    branch = 1'b0;
    #1 chk("mis_en", mem_en, 1'b0);
    @(negedge clk);
    chk("mis_flt", fault, 1'b1);
    chk("mis_vld", instr_valid, 1'b0);
    chk("mis_keep", pc, 32'h3008);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 10'h3ff;
    ld_data = 32'hdead_beef;
    @(negedge clk);
    chk("flt_ack", ld_ack, 1'b1);
    chk("flt_hold", fault, 1'b1);
    ld_addr = 10'h5; ld_data = 32'h55;
    @(negedge clk);
    ld_req = 1'b0; ld_done = 1'b1;
    @(negedge clk);
    chk("flt_clr", fault, 1'b0);
    ld_done = 1'b0;
    @(negedge clk);
    chk("rst_w", instr, 32'h11);
    branch = 1'b1; npc = 32'h3ffc;
    @(negedge clk);
    chk("pre_top", pc, 32'h3004);
    npc = 32'h4000;
    @(negedge clk);
    chk("top_w", instr, 32'hdead_beef);
    chk("top_pc", pc, 32'h3ffc);
    branch = 1'b0;
    @(negedge clk);
    chk("oor_flt", fault, 1'b1);
    chk("oor_vld", instr_valid, 1'b0);
    ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    @(negedge clk);
    chk("re_w", instr, 32'h11);
    ld_req = 1'b1; ld_addr = '0;
    ld_data = 32'ha5a5_a5a5;
    @(negedge clk);
    chk("pre_ack", ld_ack, 1'b1);
    chk("pre_vld", instr_valid, 1'b0);
    ld_req = 1'b0; ld_done = 1'b1;
    @(negedge clk);
    ld_done = 1'b0;
    @(negedge clk);
    chk("new_w", instr, 32'ha5a5_a5a5);
    chk("new_pc", pc, 32'h3000);
    #2 clr_n = 1'b0;
    #1 rst_vals("async");
    #1 clr_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_vld", instr_valid, 1'b0);
      chk("idle_en", mem_en, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
